hdmi_tmds_decode: RTL
=====================

HDMI_TMDS_DECODE -- requirements
Module: hdmi_tmds_decode

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 8: consecutive all-channel control-token cycles needed to declare lock.
REQ-002 SHALL have parameter UNLOCK_CNT, default 4: consecutive channel-mismatch cycles needed to drop lock.
REQ-003 PClk  in  1  pixel clock; one clock only, all logic on rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 TMDS_Red  in  10  channel 0 symbol; carries red plus {vsync,hsync}.
REQ-006 TMDS_Green  in  10  channel 1 symbol.
REQ-007 TMDS_Blue  in  10  channel 2 symbol.
REQ-008 Red, Green, Blue  out  8 each  decoded pixel data.
REQ-009 vsync, hsync  out  1 each  timing decoded from channel 0 control tokens.
REQ-010 activeArea  out  1  high while a data period is being output.
REQ-011 locked  out  1  high in the LOCKED state.
REQ-012 ctrl_err  out  1  one-cycle pulse per detected protocol error.

Function
REQ-013 Symbol decode SHALL be: d = sym[9] ? ~sym[7:0] : sym[7:0]; q[0] = d[0]; q[i] = sym[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]) for i = 1..7.
REQ-014 The control tokens SHALL be 10'b1101010100 -> ctrl 00, 10'b0010101011 -> 01, 10'b0101010100 -> 10, 10'b1010101011 -> 11, with ctrl = {vsync,hsync}.
REQ-015 A channel SHALL be "control" when its symbol equals one of the four tokens; otherwise it is "data".
REQ-016 The pipeline SHALL be two stages: stage 1 registers the raw symbols, stage 2 registers the decoded values and the outputs; input-to-output latency is exactly 2 cycles.
REQ-017 The FSM SHALL have the states UNLOCKED and LOCKED.
REQ-018 UNLOCKED -> LOCKED SHALL occur after LOCK_CNT consecutive cycles with all three channels control; any other cycle clears the count.
REQ-019 A mismatch cycle SHALL be one where the channels disagree on control vs. data, or where channel 1 or 2 carries a control token other than ctrl 00.
REQ-020 LOCKED -> UNLOCKED SHALL occur after UNLOCK_CNT consecutive mismatch cycles; a non-mismatch cycle clears the count.
REQ-021 ctrl_err SHALL pulse for every mismatch cycle, in either state, aligned with that cycle's output stage.
REQ-022 When LOCKED and all channels are data: activeArea = 1, Red/Green/Blue = decoded values, and vsync/hsync hold their last control values.
REQ-023 When LOCKED and all channels are control: activeArea = 0, RGB = 0, {vsync,hsync} = channel 0 ctrl.
REQ-024 During a mismatch cycle while LOCKED, all outputs SHALL hold their previous values, except ctrl_err.
REQ-025 When UNLOCKED: activeArea = 0, RGB = 0; vsync/hsync update from channel 0 only when it is control.
REQ-026 The lock counter SHALL saturate and never wrap; the transition fires on the cycle the count reaches the parameter value.

Reset
REQ-027 On Reset, the state SHALL be UNLOCKED, both counters 0, and both pipeline stages cleared.
REQ-028 On Reset, every output SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL take effect at the next edge and discard any in-flight symbols.
REQ-030 The lock sequence SHALL restart after reset deassertion.

Structure
REQ-031 The four token constants and the state encoding SHALL live in the shared HDMI package, alongside the encoder's tokens.
REQ-032 A sub-module tmds_channel_decode SHALL decode one symbol into {data[7:0], is_ctrl, ctrl[1:0]}.
REQ-033 tmds_channel_decode SHALL be combinational and instantiated three times; the top level owns the registers and the FSM.

Verification
REQ-034 Reset, then 8 cycles of 0x354 on all channels -> locked = 1 exactly 2 cycles after the 8th symbol; vsync = hsync = 0 and activeArea = 0.
REQ-035 While locked, send 0x100 then 0x200 on all channels -> RGB = 00/00/00 then FF/FF/FF, with activeArea = 1 for 2 cycles at latency 2.
REQ-036 While locked, send ch0 = 0x2AB (ctrl 11) with ch1/ch2 = 0x354 -> vsync = 1, hsync = 1, then both are held through a following data period.
REQ-037 While locked, send ch0 data with ch1/ch2 tokens for 4 cycles -> 4 ctrl_err pulses and locked falls after the 4th; 3 such cycles followed by 1 good cycle -> stays locked.
REQ-038 Send 7 token cycles, 1 data cycle, then 8 token cycles -> lock only after the second run.
REQ-039 Assert Reset for 1 cycle mid-data period -> all outputs 0 next cycle; relock requires 8 new token cycles.

Source files
------------

// File: rtl/hdmi_tmds_decode_pkg.sv
// Shared HDMI definitions: TMDS control tokens, decoder FSM states and the
// per-channel decode result.
package hdmi_tmds_decode_pkg;

  // Control-period tokens; the encoder emits the same four symbols for {vsync,hsync}.
  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       is_ctrl;
    logic [1:0] ctrl;
  } chan_dec_t;

endpackage

// File: rtl/hdmi_tmds_decode_channel.sv
// Combinational decode of one 10-bit TMDS symbol into pixel data and a
// control-token classification.
module tmds_channel_decode
  import hdmi_tmds_decode_pkg::*;
(
  input  logic [9:0] sym,
  output chan_dec_t  dec
);

  logic [7:0] d;
  logic [7:0] q;

  always_comb begin
    d    = sym[9] ? ~sym[7:0] : sym[7:0];
    q    = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  always_comb begin
    dec.data    = q;
    dec.is_ctrl = 1'b1;
    dec.ctrl    = 2'b00;
    case (sym)
      CTRL_TOKEN_00: dec.ctrl = 2'b00;
      CTRL_TOKEN_01: dec.ctrl = 2'b01;
      CTRL_TOKEN_10: dec.ctrl = 2'b10;
      CTRL_TOKEN_11: dec.ctrl = 2'b11;
      default:       dec.is_ctrl = 1'b0;
    endcase
  end

endmodule

// File: rtl/hdmi_tmds_decode.sv
// Three-channel TMDS decoder: symbol register, per-channel decode, lock FSM
// and registered pixel/sync outputs (two-cycle latency).
module hdmi_tmds_decode
  import hdmi_tmds_decode_pkg::*;
#(
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic       PClk,
  input  logic       Reset,
  input  logic [9:0] TMDS_Red,
  input  logic [9:0] TMDS_Green,
  input  logic [9:0] TMDS_Blue,
  output logic [7:0] Red,
  output logic [7:0] Green,
  output logic [7:0] Blue,
  output logic       vsync,
  output logic       hsync,
  output logic       activeArea,
  output logic       locked,
  output logic       ctrl_err,
  output state_e     state
);

  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);

  logic [9:0]    sym_r, sym_g, sym_b;
  chan_dec_t     dec_r, dec_g, dec_b;
  logic [LW-1:0] lock_cnt, lock_nxt;
  logic [UW-1:0] unlock_cnt, unlock_nxt;
  logic          all_ctrl, all_data, mismatch;

  tmds_channel_decode u_dec_r (.sym(sym_r), .dec(dec_r));
  tmds_channel_decode u_dec_g (.sym(sym_g), .dec(dec_g));
  tmds_channel_decode u_dec_b (.sym(sym_b), .dec(dec_b));

  // Channels 1 and 2 only ever legally carry the ctrl-00 token.
  always_comb begin
    all_ctrl   = dec_r.is_ctrl & dec_g.is_ctrl & dec_b.is_ctrl;
    all_data   = ~(dec_r.is_ctrl | dec_g.is_ctrl | dec_b.is_ctrl);
    mismatch   = ~(all_ctrl | all_data)
               | (dec_g.is_ctrl & (dec_g.ctrl != 2'b00))
               | (dec_b.is_ctrl & (dec_b.ctrl != 2'b00));
    lock_nxt   = (lock_cnt == LW'(LOCK_CNT)) ? lock_cnt : lock_cnt + 1'b1;
    unlock_nxt = (unlock_cnt == UW'(UNLOCK_CNT)) ? unlock_cnt : unlock_cnt + 1'b1;
  end

  assign locked = (state == ST_LOCKED);

  always_ff @(posedge PClk) begin
    if (Reset) begin
      sym_r      <= '0;
      sym_g      <= '0;
      sym_b      <= '0;
      state      <= ST_UNLOCKED;
      lock_cnt   <= '0;
      unlock_cnt <= '0;
      Red        <= '0;
      Green      <= '0;
      Blue       <= '0;
      vsync      <= 1'b0;
      hsync      <= 1'b0;
      activeArea <= 1'b0;
      ctrl_err   <= 1'b0;
    end else begin
      sym_r    <= TMDS_Red;
      sym_g    <= TMDS_Green;
      sym_b    <= TMDS_Blue;
      ctrl_err <= mismatch;
      case (state)
        ST_UNLOCKED: begin
          unlock_cnt <= '0;
          activeArea <= 1'b0;
          Red        <= '0;
          Green      <= '0;
          Blue       <= '0;
          if (dec_r.is_ctrl) {vsync, hsync} <= dec_r.ctrl;
          if (!all_ctrl) begin
            lock_cnt <= '0;
          end else if (lock_nxt == LW'(LOCK_CNT)) begin
            state    <= ST_LOCKED;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_nxt;
          end
        end
        ST_LOCKED: begin
          lock_cnt <= '0;
          // A mismatch freezes the picture; only ctrl_err reacts.
          if (mismatch) begin
            if (unlock_nxt == UW'(UNLOCK_CNT)) begin
              state      <= ST_UNLOCKED;
              unlock_cnt <= '0;
            end else begin
              unlock_cnt <= unlock_nxt;
            end
          end else begin
            unlock_cnt <= '0;
            if (all_ctrl) begin
              activeArea     <= 1'b0;
              Red            <= '0;
              Green          <= '0;
              Blue           <= '0;
              {vsync, hsync} <= dec_r.ctrl;
            end else begin
              activeArea <= 1'b1;
              Red        <= dec_r.data;
              Green      <= dec_g.data;
              Blue       <= dec_b.data;
            end
          end
        end
        default: state <= ST_UNLOCKED;
      endcase
    end
  end

endmodule
